// File: rtl/setscore_ctrl.sv
// Winning-score selection screen controller: IDLE -> SET (up/down with wrap) -> DONE pulse.
// Optional hold-to-repeat stepping is built when SETSCORE_AUTOREPEAT_EN is defined.
module setscore_ctrl #(
  parameter int MIN_SCORE     = 1,
  parameter int MAX_SCORE     = 21,
  parameter int INIT_SCORE    = 5,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_set,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_enter,
  output logic [4:0] score,
  output logic       show_setscore,
  output logic       score_done
);

  localparam logic [4:0] SMIN  = 5'(MIN_SCORE);
  localparam logic [4:0] SMAX  = 5'(MAX_SCORE);
  localparam logic [4:0] SINIT = 5'(INIT_SCORE);

  if (!(MIN_SCORE < MAX_SCORE && MAX_SCORE <= 31 && INIT_SCORE >= MIN_SCORE &&
        INIT_SCORE <= MAX_SCORE && REPEAT_DELAY > 0 && REPEAT_PERIOD > 0)) begin : g_param_chk
    $error("setscore_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, SET, DONE} state_t;

  state_t     state_p0, state_nxt;
  logic       up_p0, dn_p0, en_p0;
  logic       up_edge, dn_edge, en_edge;
  logic [4:0] score_nxt;
  logic       rpt_fire;

  function automatic logic [4:0] inc_wrap(input logic [4:0] s);
    return (s == SMAX) ? SMIN : s + 5'd1;
  endfunction

  function automatic logic [4:0] dec_wrap(input logic [4:0] s);
    return (s == SMIN) ? SMAX : s - 5'd1;
  endfunction

  assign up_edge = btn_up    & ~up_p0;
  assign dn_edge = btn_down  & ~dn_p0;
  assign en_edge = btn_enter & ~en_p0;

`ifdef SETSCORE_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(RPT_MAX + 1);
  localparam logic [CNT_W-1:0] RPT_DLY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_PER = CNT_W'(REPEAT_PERIOD);

  // rpt_cnt == 0 means no press is being tracked; it counts cycles since the last step
  logic [CNT_W-1:0] rpt_cnt, rpt_cnt_nxt;
  logic             rpt_armed, rpt_armed_nxt;

  always_comb begin
    rpt_cnt_nxt   = '0;
    rpt_armed_nxt = 1'b0;
    rpt_fire      = 1'b0;
    if (state_p0 == SET && !en_edge && (btn_up ^ btn_down)) begin
      if (up_edge || dn_edge) begin
        rpt_cnt_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (rpt_cnt != '0) begin
        if ((!rpt_armed && rpt_cnt == RPT_DLY) || (rpt_armed && rpt_cnt == RPT_PER)) begin
          rpt_fire      = 1'b1;
          rpt_cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
          rpt_armed_nxt = 1'b1;
        end else begin
          rpt_cnt_nxt   = rpt_cnt + 1'b1;
          rpt_armed_nxt = rpt_armed;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else begin
      rpt_cnt   <= rpt_cnt_nxt;
      rpt_armed <= rpt_armed_nxt;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_comb begin
    state_nxt = state_p0;
    score_nxt = score;
    case (state_p0)
      IDLE: if (req_set) state_nxt = SET;
      SET: begin
        if (en_edge) begin
          state_nxt = DONE;
        end else if (up_edge && dn_edge) begin
          score_nxt = score;
        end else if (up_edge) begin
          score_nxt = inc_wrap(score);
        end else if (dn_edge) begin
          score_nxt = dec_wrap(score);
        end else if (rpt_fire) begin
          score_nxt = btn_up ? inc_wrap(score) : dec_wrap(score);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage boundary: state, score, edge history and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0      <= IDLE;
      score         <= SINIT;
      up_p0         <= 1'b0;
      dn_p0         <= 1'b0;
      en_p0         <= 1'b0;
      show_setscore <= 1'b0;
      score_done    <= 1'b0;
    end else begin
      state_p0      <= state_nxt;
      score         <= score_nxt;
      up_p0         <= btn_up;
      dn_p0         <= btn_down;
      en_p0         <= btn_enter;
      show_setscore <= (state_nxt != IDLE);
      score_done    <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_setscore_ctrl.sv
// Scoreboard bench for setscore_ctrl; expectations follow SETSCORE_AUTOREPEAT_EN when defined.
module tb_setscore_ctrl;

`ifdef SETSCORE_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_set = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_enter = 1'b0;
  logic [4:0] score;
  logic       show_setscore;
  logic       score_done;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string      tag;
    logic [4:0] score;
    logic       show;
    logic       done;
  } exp_t;

  exp_t exp_q[$];

  setscore_ctrl #(
    .MIN_SCORE(1), .MAX_SCORE(21), .INIT_SCORE(5),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk), .reset(reset), .req_set(req_set),
    .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter),
    .score(score), .show_setscore(show_setscore), .score_done(score_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int s, input bit sh, input bit d);
    exp_t e;
    e.tag = tag; e.score = 5'(s); e.show = sh; e.done = d;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, then compare the DUT against the oldest pending expectation
  task automatic step(input bit r, input bit u, input bit d, input bit e);
    exp_t ex;
    @(negedge clk);
    req_set = r; btn_up = u; btn_down = d; btn_enter = e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      chk({ex.tag, ".score"}, int'(score), int'(ex.score));
      chk({ex.tag, ".show"}, int'(show_setscore), int'(ex.show));
      chk({ex.tag, ".done"}, int'(score_done), int'(ex.done));
    end
  endtask

  task automatic press(input string tag, input bit u, input bit d, input int s_after);
    expect_out({tag, "_press"}, s_after, 1'b1, 1'b0);
    step(1'b0, u, d, 1'b0);
    expect_out({tag, "_rel"}, s_after, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    int ex;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      expect_out("reset_idle", 5, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end

    expect_out("enter_set", 5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) press("up", 1'b1, 1'b0, 6 + i);
    expect_out("confirm", 8, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("after_done", 8, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("idle_hold", 8, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    expect_out("held_entry", 8, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("held_no_edge", 8, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("held_release", 8, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) press("down", 1'b0, 1'b1, 7 - i);
    press("wrap_down", 1'b0, 1'b1, 21);
    press("wrap_up", 1'b1, 1'b0, 1);
    press("wrap_down2", 1'b0, 1'b1, 21);
    expect_out("req_in_set", 21, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    press("up_dn_same", 1'b1, 1'b1, 21);
    expect_out("up_enter", 21, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    expect_out("req_in_done", 21, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("idle2", 21, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expect_out("reset2", 5, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("enter_set2", 5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      ex = 6;
      if (AR && k >= 10) ex = 7 + (k - 10) / 4;
      expect_out($sformatf("hold_%0d", k), ex, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    cur = AR ? 11 : 6;
    expect_out("hold_release", cur, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    while (cur < 12) begin
      cur++;
      press("to12", 1'b1, 1'b0, cur);
    end

    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst.score", int'(score), 5);
    chk("async_rst.show", int'(show_setscore), 0);
    chk("async_rst.done", int'(score_done), 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk("in_rst.done", int'(score_done), 0);
      chk("in_rst.show", int'(show_setscore), 0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_out("post_rst", 5, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
